// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: word width, canonical NOP and the instruction-memory FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x XLEN storage: one synchronous write port and one asynchronous read port, no reset.
module imem_array #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: post-reset clearing sweep, streaming loader with overflow
// detection, and an asynchronous fetch port that returns NOP while the array is busy.
module inst_mem_ctrl #(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            pc_fault,
  output logic            busy,
  input  logic            clr_req,
  input  logic            ld_start,
  input  logic [AW-1:0]   ld_base,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_done,
  output logic            ld_err
);

  import riscv_pkg::*;

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  imem_state_t     state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ld_done_q, ld_done_d;
  logic            ld_err_q, ld_err_d;

  logic            we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ld_done_q <= ld_done_d;
      ld_err_q  <= ld_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ld_done_d = 1'b0;
    ld_err_d  = ld_err_q;
    we        = 1'b0;
    wdata     = '0;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastIdx) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // clr_req wins over a simultaneous ld_start.
        if (clr_req) begin
          ptr_d   = '0;
          state_d = CLEAR;
        end else if (ld_start) begin
          ptr_d    = ld_base;
          ld_err_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          wdata = ld_data;
          ptr_d = ptr_q + 1'b1;
          if (ld_last) begin
            state_d   = IDLE;
            ld_done_d = 1'b1;
          end else if (ptr_q == LastIdx) begin
            // Burst ran past the top of the array: stop rather than wrap to index 0.
            state_d   = IDLE;
            ld_done_d = 1'b1;
            ld_err_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  imem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (wdata),
    .raddr_i (pc[AW+1:2]),
    .rdata_o (rdata)
  );

  assign busy       = (state_q != IDLE);
  assign inst_valid = (state_q == IDLE);
  assign inst       = inst_valid ? rdata : XLEN'(INST_NOP);
  assign ld_ready   = (state_q == LOAD);
  assign ld_done    = ld_done_q;
  assign ld_err     = ld_err_q;
  assign pc_fault   = (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != 32'd0);

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed bench for inst_mem_ctrl with a cycle-level reference model checked every cycle.
module tb_inst_mem_ctrl;

  localparam int DEPTH = 128;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h1FC;
  logic [31:0] inst;
  logic        inst_valid, pc_fault, busy;
  logic        clr_req = 1'b0;
  logic        ld_start = 1'b0;
  logic [6:0]  ld_base = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_done, ld_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  inst_mem_ctrl #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc_fault   (pc_fault),
    .busy       (busy),
    .clr_req    (clr_req),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_done    (ld_done),
    .ld_err     (ld_err)
  );

  // Reference model: 0 = clearing, 1 = idle, 2 = loading.
  int          m_mode;
  int          m_left;
  int          m_widx;
  logic        m_done, m_err;
  logic [31:0] m_mem [DEPTH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_left <= DEPTH;
      m_done <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_mode == 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_mode <= 1;
          for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'd0;
        end
      end else if (m_mode == 1) begin
        if (clr_req) begin
          m_mode <= 0;
          m_left <= DEPTH;
        end else if (ld_start) begin
          m_mode <= 2;
          m_widx <= int'(ld_base);
          m_err  <= 1'b0;
        end
      end else if (ld_valid) begin
        m_mem[m_widx] <= ld_data;
        m_widx <= m_widx + 1;
        if (ld_last) begin
          m_mode <= 1;
          m_done <= 1'b1;
        end else if (m_widx == DEPTH - 1) begin
          m_mode <= 1;
          m_done <= 1'b1;
          m_err  <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [31:0] e_inst;
        e_inst = (m_mode == 1) ? m_mem[(pc / 4) % DEPTH] : NOP;
        check("busy", 32'(busy), 32'(m_mode != 1));
        check("inst_valid", 32'(inst_valid), 32'(m_mode == 1));
        check("inst", inst, e_inst);
        check("pc_fault", 32'(pc_fault), 32'((pc % 4 != 0) || (pc >= 4 * DEPTH)));
        check("ld_ready", 32'(ld_ready), 32'(m_mode == 2));
        check("ld_done", 32'(ld_done), 32'(m_done));
        check("ld_err", 32'(ld_err), 32'(m_err));
        if (ld_done === 1'b1) done_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    int cnt;
    int d0;
    step();
    chk_en = 1'b1;
    step();
    // Reset sweep with ld_start held high throughout.
    ld_start = 1'b1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
    end
    ld_start = 1'b0;
    check("sweep_cycles", cnt, 128);
    check("post_sweep_valid", 32'(inst_valid), 32'd1);
    check("post_sweep_1fc", inst, 32'h0);
    step();

    // Load 3 words at base 4 with bubbles.
    d0 = done_cnt;
    ld_base = 7'd4;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("ld_ready_in_load", 32'(ld_ready), 32'd1);
    step();
    send(32'h0050_0093, 1'b0);
    step();
    send(32'h00A0_0113, 1'b0);
    step();
    step();
    send(32'h0020_81B3, 1'b1);
    step();
    step();
    check("load_done_pulses", done_cnt - d0, 32'd1);
    pc = 32'h10; #1 check("rd_10", inst, 32'h0050_0093);
    pc = 32'h14; #1 check("rd_14", inst, 32'h00A0_0113);
    pc = 32'h18; #1 check("rd_18", inst, 32'h0020_81B3);
    pc = 32'h1C; #1 check("rd_1c", inst, 32'h0);
    step();

    // Overflow from base 126 with no ld_last.
    ld_base = 7'd126;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 32'hAAAA_0001;
    step();
    ld_data = 32'hAAAA_0002;
    step();
    ld_data = 32'hAAAA_0003;
    check("ovf_err", 32'(ld_err), 32'd1);
    check("ovf_done", 32'(ld_done), 32'd1);
    check("ovf_ready", 32'(ld_ready), 32'd0);
    step();
    ld_valid = 1'b0;
    pc = 32'h1F8; #1 check("rd_1f8", inst, 32'hAAAA_0001);
    pc = 32'h1FC; #1 check("rd_1fc", inst, 32'hAAAA_0002);
    pc = 32'h0;   #1 check("rd_0", inst, 32'h0);
    step();

    // clr_req beats ld_start.
    pc = 32'h10;
    clr_req = 1'b1;
    ld_start = 1'b1;
    ld_base = 7'd20;
    step();
    clr_req = 1'b0;
    ld_start = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    wait_idle("clr");
    check("clr_err_kept", 32'(ld_err), 32'd1);
    pc = 32'h10; #1 check("clr_10", inst, 32'h0);
    pc = 32'h18; #1 check("clr_18", inst, 32'h0);
    step();

    // Async reset in the middle of a burst.
    d0 = done_cnt;
    ld_base = 7'd8;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    send(32'h1234_5678, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_ready_drop", 32'(ld_ready), 32'd0);
    step();
    rst = 1'b0;
    wait_idle("rst");
    step();
    check("rst_no_done", done_cnt - d0, 32'd0);
    check("rst_err_clr", 32'(ld_err), 32'd0);
    pc = 32'h20; #1 check("rst_wiped", inst, 32'h0);
    step();

    // Fetch fault decoding.
    pc = 32'h6;   #1 check("fault_misalign", 32'(pc_fault), 32'd1);
    step();
    pc = 32'h200; #1 check("fault_range", 32'(pc_fault), 32'd1);
    step();
    pc = 32'h1FC; #1 check("fault_none", 32'(pc_fault), 32'd0);
    step();
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
